lfsr_crc32_check: RTL and testbench
===================================

# lfsr_crc32_check

Streaming Ethernet FCS checker: the receive-side counterpart of the CRC-32 generator built on `lfsr`. It consumes a byte stream whose frames end with a 4-byte FCS and runs the reflected CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF) across the whole frame. At end of frame it compares the LFSR state against the residue constant and flags the frame good or bad. It sits between the MAC receive framer and the packet FIFO, optionally stripping the FCS.

## Interface
- `MIN_FRAME_LEN`, default 5: minimum accepted frame length in bytes, FCS included; shorter frames are runts.
- `clk` in 1: sole clock; all logic rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `s_axis_tdata` in 8: input byte.
- `s_axis_tvalid` in 1: input byte valid.
- `s_axis_tready` out 1: input accepted when tvalid && tready.
- `s_axis_tlast` in 1: last byte of frame (final FCS byte).
- `s_axis_tuser` in 1: upstream error; sampled on any accepted byte, sticky for the frame.
- `m_axis_tdata` out 8: output byte.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: last output byte of frame.
- `m_axis_tuser` out 1: frame bad; meaningful only with `m_axis_tlast`.
- `status_good` out 1: one-cycle pulse per good frame.
- `status_bad` out 1: one-cycle pulse per bad frame (CRC, upstream error or runt).
- `status_runt` out 1: one-cycle pulse per runt; always coincides with `status_bad`.

## Operation
- CRC state: 32-bit register, reflected Galois form, 8 bits per accepted byte, LSB first; loaded with 0xFFFFFFFF at reset and after every accepted tlast.
- Verdict on accepted tlast: good iff next-state == 0xDEBB20E3 and the sticky error is clear and length >= `MIN_FRAME_LEN`.
- Length counter: 16 bits, saturating at 0xFFFF; cleared with the CRC state.
- Output register: single stage. `s_axis_tready` = `!m_axis_tvalid || m_axis_tready` whenever an accepted byte would load the output register; otherwise 1.
- Strip buffer (macro enabled): 4-entry byte shift register with count 0..4.
  - Accepted byte with count < 4: shift in, count++, no output.
  - Accepted byte with count == 4: oldest byte moves to the output register, new byte shifts in.
  - Accepted tlast with count == 4: emitted byte carries tlast=1 and tuser=!good; buffer count cleared.
  - Runt (tlast with count < 4, or length < `MIN_FRAME_LEN`): no tlast emitted if no bytes were output. With `MIN_FRAME_LEN` > 5 and bytes already output, tlast goes on the last payload byte with tuser=1.
- Status pulses are registered and asserted for exactly one cycle, even if `m_axis_tready` is low.
- Back-to-back frames: the byte after tlast starts a new frame with a fresh CRC state in the same cycle; no bubble is required.

## Timing
- Reset values: `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tuser`, `m_axis_tdata`, and all status outputs are 0. `s_axis_tready` is 1. CRC state is 0xFFFFFFFF; buffer count and length are 0.
- Latency with strip: payload byte k appears on `m_axis` the cycle after input byte k+4 is accepted.
- Latency without strip: each byte appears the cycle after it is accepted.
- Status pulse: asserted the cycle after tlast is accepted, the same cycle the tlast byte becomes valid on `m_axis`.
- Output stall: `m_axis_tdata`, `m_axis_tlast` and `m_axis_tuser` hold stable while `m_axis_tvalid && !m_axis_tready`.
- Reset mid-frame: the partial frame is discarded and no status pulse is issued. The next frame is checked from a clean state.

## Configuration
- `LFSR_CRC32_CHECK_STRIP_EN` defined: 4-byte strip buffer is instantiated, FCS bytes never appear on `m_axis`, and latency is as stated under Timing.
- `LFSR_CRC32_CHECK_STRIP_EN` undefined:
  - No buffer; every input byte passes through, including the FCS.
  - `m_axis_tlast` is set on the original last byte, with tuser set to the verdict.
  - Runts pass through with tuser=1.

## Test plan
- Good frame: "123456789" (0x31..0x39) + 0x26 0x39 0xF4 0xCB.
  - Strip: 9 bytes out, last is 0x39 with tlast=1, tuser=0, plus one `status_good` pulse.
  - No strip: 13 bytes out, tlast on 0xCB.
- Corrupt FCS: same frame with final byte 0xCA -> tuser=1 on tlast, one `status_bad` pulse, `status_good` stays 0.
- Runt: 4-byte frame 0x01 0x02 0x03 0x04 with tlast.
  - Strip: no `m_axis` beats, `status_bad` and `status_runt` pulse together.
  - No strip: 4 beats, tuser=1.
- Backpressure: good frame with `m_axis_tready` toggling 1/0 every cycle -> identical byte sequence, no drops or duplicates, data stable while stalled.
- Back-to-back: good frame, bad frame, good frame with continuous tvalid -> verdicts good, bad, good, in order.
- Reset mid-frame: assert `rst` after 6 bytes of a frame, then send the good frame -> only that frame reported good; outputs read 0 during reset.

Source files
------------

// File: rtl/lfsr_crc32_check.sv
// lfsr_crc32_check: streaming Ethernet FCS checker.
// Runs the reflected CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF) over each frame,
// FCS included, and calls the frame good when the final state equals the
// residue 0xDEBB20E3, no upstream error was seen and the frame is long enough.
// Optional macro LFSR_CRC32_CHECK_STRIP_EN: a 4-byte delay buffer holds back
// the trailing bytes so the FCS never reaches m_axis. Without the macro every
// byte passes straight through to a single output register.
module lfsr_crc32_check #(
  parameter int MIN_FRAME_LEN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       status_good,
  output logic       status_bad,
  output logic       status_runt
);

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
  localparam logic [15:0] MIN_LEN       = 16'(MIN_FRAME_LEN);

  // One byte of the reflected CRC, LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  logic [31:0] crc_q, crc_next;
  logic [15:0] len_q, len_next;
  logic        err_q, err_next;
  logic        accept;
  logic        frame_good;
  logic        frame_runt;
  logic        would_load;
  logic        load_out;
  logic [7:0]  emit_data;

`ifdef LFSR_CRC32_CHECK_STRIP_EN
  logic [7:0] hold_q [4];
  logic [2:0] cnt_q;

  // Delay line: newest byte enters at index 3, oldest sits at index 0.
  // NOTE: the byte storage has no reset; cnt_q alone says which entries are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_q[0] <= hold_q[1];
      hold_q[1] <= hold_q[2];
      hold_q[2] <= hold_q[3];
      hold_q[3] <= s_axis_tdata;
    end
  end

  // Fill count: saturates at 4, restarts after each accepted tlast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      if (s_axis_tlast) begin
        cnt_q <= '0;
      end else if (cnt_q != 3'd4) begin
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

  // Only a full buffer pushes a byte out; until then input never stalls.
  assign would_load = (cnt_q == 3'd4);
  assign emit_data  = hold_q[0];
`else
  assign would_load = 1'b1;
  assign emit_data  = s_axis_tdata;
`endif

  assign s_axis_tready = would_load ? (!m_axis_tvalid || m_axis_tready) : 1'b1;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign load_out      = accept && would_load;

  // Look-ahead of the frame state including the byte on the input.
  always_comb begin
    // NOTE: every signal gets its value unconditionally here, so no latch is inferred.
    crc_next   = crc_step(crc_q, s_axis_tdata);
    len_next   = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
    err_next   = err_q | s_axis_tuser;
    frame_runt = (len_next < MIN_LEN);
    frame_good = (crc_next == CRC_RESIDUE) && !err_next && !frame_runt;
  end

  // Running CRC, length and sticky error; reloaded after every accepted tlast.
  // NOTE: non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= CRC_INIT;
      len_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      if (s_axis_tlast) begin
        crc_q <= CRC_INIT;
        len_q <= '0;
        err_q <= 1'b0;
      end else begin
        crc_q <= crc_next;
        len_q <= len_next;
        err_q <= err_next;
      end
    end
  end

  // Output register: loads only when empty or draining, holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else if (load_out) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= emit_data;
      m_axis_tlast  <= s_axis_tlast;
      m_axis_tuser  <= s_axis_tlast && !frame_good;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Verdict pulses, one cycle after the accepted tlast, independent of backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_good <= 1'b0;
      status_bad  <= 1'b0;
      status_runt <= 1'b0;
    end else begin
      status_good <= accept && s_axis_tlast && frame_good;
      status_bad  <= accept && s_axis_tlast && !frame_good;
      status_runt <= accept && s_axis_tlast && frame_runt;
    end
  end

endmodule

// File: tb/tb_lfsr_crc32_check.sv
// Bench for lfsr_crc32_check. The reference model computes the standard CRC-32
// of each frame's payload and compares it with the transmitted FCS bytes, then
// derives the expected m_axis beats and status verdicts from the frame rules.
// Works for both builds of LFSR_CRC32_CHECK_STRIP_EN.
module tb_lfsr_crc32_check;

  localparam int MIN_LEN = 5;
`ifdef LFSR_CRC32_CHECK_STRIP_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif

  typedef logic [7:0] byte_q_t [$];
  typedef struct { logic [7:0] data; logic last; logic user; } beat_t;
  typedef struct { logic good; logic runt; logic has_beat; } verdict_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_tdata = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       s_axis_tlast = 1'b0;
  logic       s_axis_tuser = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       status_good;
  logic       status_bad;
  logic       status_runt;

  lfsr_crc32_check #(.MIN_FRAME_LEN(MIN_LEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .status_good   (status_good),
    .status_bad    (status_bad),
    .status_runt   (status_runt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  beat_t    exp_q [$];
  verdict_t stat_q [$];

  int rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random
  int gap_pct  = 0;   // chance of an idle input cycle before each byte
  bit mon_en   = 1'b1;

  int         n_beats = 0;
  int         n_good  = 0;
  int         n_bad   = 0;
  int         n_runt  = 0;
  logic [7:0] last_tl_data = '0;
  logic       last_tl_user = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Plain bit-serial CRC-32 with final inversion.
  function automatic logic [31:0] ref_crc32(input byte_q_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ b[i][k]) c = {1'b0, c[31:1]} ^ 32'hEDB8_8320;
        else                c = {1'b0, c[31:1]};
      end
    end
    return ~c;
  endfunction

  function automatic byte_q_t with_fcs(input byte_q_t p);
    byte_q_t     r;
    logic [31:0] crc;
    r   = p;
    crc = ref_crc32(p);
    r.push_back(crc[7:0]);
    r.push_back(crc[15:8]);
    r.push_back(crc[23:16]);
    r.push_back(crc[31:24]);
    return r;
  endfunction

  // Ready pattern for the downstream side.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = ($urandom_range(99) < 70);
    endcase
  end

  // Called at posedge+1; returns at posedge+1 after the byte is accepted.
  task automatic send_byte(input logic [7:0] d, input logic l, input logic u);
    int budget;
    while (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
      s_axis_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    budget = 0;
    forever begin
      @(negedge clk);
      if (s_axis_tready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      budget++;
      if (budget > 500) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  // Model the frame, queue its expectations, then drive it.
  task automatic send_frame(input byte_q_t f, input int err_idx);
    verdict_t v;
    beat_t    bt;
    byte_q_t  p;
    int       len;
    int       n_out;
    logic     fcs_ok;
    len = f.size();
    for (int i = 0; i < len - 4; i++) p.push_back(f[i]);
    fcs_ok = 1'b0;
    if (len >= 4) fcs_ok = (ref_crc32(p) == {f[len-1], f[len-2], f[len-3], f[len-4]});
    v.runt     = (len < MIN_LEN);
    v.good     = !v.runt && (err_idx < 0) && fcs_ok;
    n_out      = STRIP ? ((len > 4) ? len - 4 : 0) : len;
    v.has_beat = (n_out > 0);
    for (int i = 0; i < n_out; i++) begin
      bt.data = f[i];
      bt.last = (i == n_out - 1);
      bt.user = bt.last && !v.good;
      exp_q.push_back(bt);
    end
    stat_q.push_back(v);
    for (int i = 0; i < len; i++) send_byte(f[i], i == len - 1, i == err_idx);
  endtask

  // Wait for all expectations to be consumed; ends at posedge+1.
  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && stat_q.size() == 0) break;
    end
    check("drain_left", exp_q.size() + stat_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Compare process: beats, verdict pulses and stall stability every cycle.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  logic       prev_user;
  always @(negedge clk) begin
    beat_t    e;
    verdict_t s;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata},
                            {1'b1, prev_last, prev_user, prev_data});
      if (mon_en) begin
        if (status_good || status_bad || status_runt) begin
          if (stat_q.size() == 0) begin
            check("status_unexpected", {status_good, status_bad, status_runt}, 0);
          end else begin
            s = stat_q.pop_front();
            check("status_verdict", {status_good, status_bad, status_runt}, {s.good, !s.good, s.runt});
            if (s.has_beat) check("status_align", {m_axis_tvalid, m_axis_tlast}, 2'b11);
          end
          if (status_good) n_good++;
          if (status_bad)  n_bad++;
          if (status_runt) n_runt++;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            check("beat_unexpected", {m_axis_tlast, m_axis_tdata}, 9'h1FF ^ {m_axis_tlast, ~m_axis_tdata} ^ 9'h100);
            check("beat_extra", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("beat_data_last", {m_axis_tlast, m_axis_tdata}, {e.last, e.data});
            if (e.last) check("beat_user", m_axis_tuser, e.user);
          end
          n_beats++;
          if (m_axis_tlast) begin
            last_tl_data = m_axis_tdata;
            last_tl_user = m_axis_tuser;
          end
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      prev_user  = m_axis_tuser;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t known, good_f, bad_f, runt_f, p, f;
    int sb, sg, sbad, sr, kind, plen, err;

    for (int i = 0; i < 9; i++) known.push_back(8'h31 + 8'(i));

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, status_good, status_bad, status_runt, s_axis_tready},
          {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
    @(posedge clk); #1;
    rst = 1'b0;

    // Pin the model against the textbook check value and FCS byte order.
    check("model_crc_check_value", ref_crc32(known), 32'hCBF4_3926);
    good_f = with_fcs(known);
    check("model_fcs_bytes", {good_f[9], good_f[10], good_f[11], good_f[12]}, 32'h2639_F4CB);

    // Good frame.
    sb = n_beats; sg = n_good; sbad = n_bad;
    send_frame(good_f, -1);
    drain();
    check("good_beats", n_beats - sb, STRIP ? 9 : 13);
    check("good_pulses", {n_good - sg, n_bad - sbad}, {32'd1, 32'd0});
    check("good_last_byte", {last_tl_data, last_tl_user}, {(STRIP ? 8'h39 : 8'hCB), 1'b0});

    // Corrupt FCS.
    bad_f = good_f;
    bad_f[12] = 8'hCA;
    sg = n_good; sbad = n_bad;
    send_frame(bad_f, -1);
    drain();
    check("corrupt_pulses", {n_good - sg, n_bad - sbad}, {32'd0, 32'd1});
    check("corrupt_last_byte", {last_tl_data, last_tl_user}, {(STRIP ? 8'h39 : 8'hCA), 1'b1});

    // Runt.
    runt_f = {8'h01, 8'h02, 8'h03, 8'h04};
    sb = n_beats; sbad = n_bad; sr = n_runt;
    send_frame(runt_f, -1);
    drain();
    check("runt_beats", n_beats - sb, STRIP ? 0 : 4);
    check("runt_pulses", {n_bad - sbad, n_runt - sr}, {32'd1, 32'd1});

    // Shortest legal frame: one payload byte plus FCS.
    p = {8'hA5};
    sb = n_beats; sg = n_good;
    send_frame(with_fcs(p), -1);
    drain();
    check("minlen_good", {n_good - sg, n_beats - sb}, {32'd1, (STRIP ? 32'd1 : 32'd5)});

    // Upstream error on a mid-frame byte.
    sbad = n_bad;
    send_frame(good_f, 3);
    drain();
    check("tuser_bad", n_bad - sbad, 1);

    // Backpressure: ready toggling every cycle.
    rdy_mode = 1;
    sb = n_beats; sg = n_good;
    send_frame(good_f, -1);
    drain();
    check("bp_good", {n_good - sg, n_beats - sb}, {32'd1, (STRIP ? 32'd9 : 32'd13)});
    rdy_mode = 0;

    // Back-to-back good, bad, good with continuous tvalid.
    sg = n_good; sbad = n_bad;
    send_frame(good_f, -1);
    send_frame(bad_f, -1);
    send_frame(good_f, -1);
    drain();
    check("b2b_pulses", {n_good - sg, n_bad - sbad}, {32'd2, 32'd1});

    // Reset in the middle of a frame.
    mon_en = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(known[i], 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_outputs",
          {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, status_good, status_bad, status_runt, s_axis_tready},
          {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    stat_q.delete();
    mon_en = 1'b1;
    sg = n_good; sbad = n_bad;
    send_frame(good_f, -1);
    drain();
    check("after_reset_pulses", {n_good - sg, n_bad - sbad}, {32'd1, 32'd0});

    // Randomized frames with random gaps and backpressure.
    rdy_mode = 2;
    gap_pct  = 30;
    for (int n = 0; n < 40; n++) begin
      p.delete();
      kind = int'($urandom_range(9));
      plen = int'($urandom_range(20));
      for (int i = 0; i < plen; i++) p.push_back(8'($urandom));
      f = with_fcs(p);
      if (kind == 0) begin
        f[f.size() - 1 - int'($urandom_range(3))] ^= 8'h10;
      end else if (kind == 1) begin
        f.delete();
        plen = int'($urandom_range(1, 6));
        for (int i = 0; i < plen; i++) f.push_back(8'($urandom));
      end
      err = (kind == 2) ? int'($urandom_range(f.size() - 1)) : -1;
      send_frame(f, err);
    end
    drain();
    rdy_mode = 0;
    gap_pct  = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
